// File: rtl/bcd_chain_ctrl.sv
// bcd_chain_ctrl
//
// Sequencer for a chain of NDIG single-digit BCD counters. It turns start /
// stop / clear command strobes into a count tick divided by DIV. The tick
// ripples to the per-digit enables through the digits' done flags, so the
// chain behaves as one multi-digit decimal counter.
//
// Optional feature: define BCD_CHAIN_CTRL_LIMIT_EN to compile in the
// terminal-count compare (q_in == limit -> DONE, pulse hit).
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   begin / resume counting
//   stop         in   pause counting
//   clear        in   zero all digits, return to IDLE (highest priority)
//   digit_done   in   per-digit done flag (Q == 9), bit 0 = LSD
//   q_in         in   concatenated digit values, digit 0 in [3:0]
//   limit        in   BCD terminal count (limit feature only)
//   digit_en     out  per-digit enable, combinational
//   digit_clr_n  out  active-low clear to all digits, registered
//   running      out  state == RUN
//   wrap         out  one-cycle pulse after the chain rolls 9..9 -> 0..0
//   hit          out  one-cycle pulse after reaching limit
//   state        out  IDLE=0, RUN=1, PAUSE=2, DONE=3

module bcd_chain_ctrl #(
    parameter int unsigned NDIG = 4,
    parameter int unsigned DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic [NDIG-1:0]     digit_done,
    input  logic [4*NDIG-1:0]   q_in,
    input  logic [4*NDIG-1:0]   limit,
    output logic [NDIG-1:0]     digit_en,
    output logic                digit_clr_n,
    output logic                running,
    output logic                wrap,
    output logic                hit,
    output logic [1:0]          state
);

    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PreLast = PW'(DIV - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          clr_n_q, clr_n_d;
    logic          wrap_q, wrap_d;
    logic          hit_q, hit_d;
    logic          tick;
    logic          match;

`ifdef BCD_CHAIN_CTRL_LIMIT_EN
    assign match = (q_in == limit);
`else
    assign match = 1'b0;
    logic unused_limit_inputs;
    assign unused_limit_inputs = ^{q_in, limit};
`endif

    assign tick = (state_q == StRun) && (pre_q == PreLast) && !stop && !clear;

    // Ripple enable: digit i advances only when every lower digit shows 9.
    always_comb begin
        logic carry;
        carry    = tick;
        digit_en = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            digit_en[i] = carry;
            carry       = carry & digit_done[i];
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        clr_n_d = 1'b1;
        hit_d   = 1'b0;
        wrap_d  = tick & (&digit_done);

        if (clear) begin
            state_d = StIdle;
            pre_d   = '0;
            clr_n_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StPause: begin
                    if (!stop && start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        // Prescaler holds so a resume finishes the partial period.
                        state_d = StPause;
                    end else begin
                        pre_d = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
                        if (match) begin
                            state_d = StDone;
                            hit_d   = 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pre_q   <= '0;
            clr_n_q <= 1'b0;
            wrap_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            clr_n_q <= clr_n_d;
            wrap_q  <= wrap_d;
            hit_q   <= hit_d;
        end
    end

    assign digit_clr_n = clr_n_q;
    assign running     = (state_q == StRun);
    assign wrap        = wrap_q;
    assign hit         = hit_q;
    assign state       = state_q;

endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// Directed bench for bcd_chain_ctrl with NDIG=4, DIV=4. A small behavioural
// chain of BCD digits sits on the DUT outputs so q_in / digit_done are real.

module tb_bcd_chain_ctrl;

    localparam int unsigned NDIG = 4;
    localparam int unsigned DIV  = 4;

    logic                clk;
    logic                reset;
    logic                start;
    logic                stop;
    logic                clear;
    logic [NDIG-1:0]     digit_done;
    logic [4*NDIG-1:0]   q_in;
    logic [4*NDIG-1:0]   limit;
    logic [NDIG-1:0]     digit_en;
    logic                digit_clr_n;
    logic                running;
    logic                wrap;
    logic                hit;
    logic [1:0]          state;

    logic                preload_en;
    logic [4*NDIG-1:0]   preload_val;

    int pass_cnt;
    int check_cnt;

    bcd_chain_ctrl #(
        .NDIG (NDIG),
        .DIV  (DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .digit_done  (digit_done),
        .q_in        (q_in),
        .limit       (limit),
        .digit_en    (digit_en),
        .digit_clr_n (digit_clr_n),
        .running     (running),
        .wrap        (wrap),
        .hit         (hit),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural digit counters.
    always_ff @(posedge clk) begin
        if (!digit_clr_n) begin
            q_in <= '0;
        end else if (preload_en) begin
            q_in <= preload_val;
        end else begin
            for (int i = 0; i < int'(NDIG); i++) begin
                if (digit_en[i]) begin
                    q_in[4*i +: 4] <= (q_in[4*i +: 4] == 4'd9) ? 4'd0 : q_in[4*i +: 4] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        digit_done = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            digit_done[i] = (q_in[4*i +: 4] == 4'd9);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        check_cnt++;
        if (digit_clr_n !== 1'b0) $display("FAIL rst_clr_in_reset: got %b want 0", digit_clr_n);
        else pass_cnt++;
        reset = 1'b0;
        // Last reset edge has passed; this is the first post-reset cycle.
        check_cnt++;
        if (digit_clr_n !== 1'b0) $display("FAIL rst_clr_first: got %b want 0", digit_clr_n);
        else pass_cnt++;
        check_cnt++;
        if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state);
        else pass_cnt++;
        check_cnt++;
        if ({digit_en, running, wrap, hit} !== 7'd0)
            $display("FAIL rst_outputs: got %b want 0000000", {digit_en, running, wrap, hit});
        else pass_cnt++;
        step();
        check_cnt++;
        if (digit_clr_n !== 1'b1) $display("FAIL rst_clr_release: got %b want 1", digit_clr_n);
        else pass_cnt++;
        check_cnt++;
        if (q_in !== 16'h0000) $display("FAIL rst_q: got %h want 0000", q_in);
        else pass_cnt++;
    endtask

    task automatic test_count();
        logic [NDIG-1:0] exp_en;
        start = 1'b1;
        step();
        start = 1'b0;
        check_cnt++;
        if (running !== 1'b1) $display("FAIL cnt_running: got %b want 1", running);
        else pass_cnt++;
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 3) exp_en = (c == 39) ? 4'b0011 : 4'b0001;
            else            exp_en = 4'b0000;
            check_cnt++;
            if (digit_en !== exp_en)
                $display("FAIL cnt_en cycle %0d: got %b want %b", c, digit_en, exp_en);
            else pass_cnt++;
            step();
        end
        check_cnt++;
        if (q_in !== 16'h0010) $display("FAIL cnt_q: got %h want 0010", q_in);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        start = 1'b1;
        stop  = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        check_cnt++;
        if (state !== 2'd0) $display("FAIL clr_state: got %0d want 0", state);
        else pass_cnt++;
        check_cnt++;
        if (digit_clr_n !== 1'b0) $display("FAIL clr_low: got %b want 0", digit_clr_n);
        else pass_cnt++;
        check_cnt++;
        if (running !== 1'b0) $display("FAIL clr_running: got %b want 0", running);
        else pass_cnt++;
        step();
        check_cnt++;
        if (digit_clr_n !== 1'b1) $display("FAIL clr_high: got %b want 1", digit_clr_n);
        else pass_cnt++;
        check_cnt++;
        if (q_in !== 16'h0000) $display("FAIL clr_q: got %h want 0000", q_in);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        preload_en  = 1'b1;
        preload_val = 16'h9999;
        step();
        preload_en  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check_cnt++;
        if (digit_en !== 4'hF) $display("FAIL wrap_en: got %b want 1111", digit_en);
        else pass_cnt++;
        check_cnt++;
        if (wrap !== 1'b0) $display("FAIL wrap_early: got %b want 0", wrap);
        else pass_cnt++;
        step();
        check_cnt++;
        if (q_in !== 16'h0000) $display("FAIL wrap_q: got %h want 0000", q_in);
        else pass_cnt++;
        check_cnt++;
        if (wrap !== 1'b1) $display("FAIL wrap_pulse: got %b want 1", wrap);
        else pass_cnt++;
        step();
        check_cnt++;
        if ({wrap, running} !== 2'b01) $display("FAIL wrap_after: got %b want 01", {wrap, running});
        else pass_cnt++;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    task automatic test_pause_resume();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        // Prescaler is at 2 here.
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_cnt++;
        if (state !== 2'd2) $display("FAIL pause_state: got %0d want 2", state);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            check_cnt++;
            if (digit_en !== 4'b0000) $display("FAIL pause_en hold %0d: got %b want 0000", i, digit_en);
            else pass_cnt++;
            step();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check_cnt++;
        if ({running, digit_en[0]} !== 2'b10)
            $display("FAIL resume_first: got %b want 10", {running, digit_en[0]});
        else pass_cnt++;
        step();
        check_cnt++;
        if (digit_en[0] !== 1'b1) $display("FAIL resume_tick: got %b want 1", digit_en[0]);
        else pass_cnt++;
        step();
        check_cnt++;
        if (q_in !== 16'h0001) $display("FAIL resume_q: got %h want 0001", q_in);
        else pass_cnt++;
        step();
        step();
        step();
        // Tick cycle: a stop here must swallow the tick.
        stop = 1'b1;
        #1;
        check_cnt++;
        if (digit_en !== 4'b0000) $display("FAIL stop_tick_en: got %b want 0000", digit_en);
        else pass_cnt++;
        step();
        stop = 1'b0;
        check_cnt++;
        if ({state, q_in} !== {2'd2, 16'h0001})
            $display("FAIL stop_tick_q: got %0d/%h want 2/0001", state, q_in);
        else pass_cnt++;
        start = 1'b1;
        step();
        start = 1'b0;
        check_cnt++;
        if (digit_en[0] !== 1'b1) $display("FAIL stop_tick_resume: got %b want 1", digit_en[0]);
        else pass_cnt++;
        step();
        check_cnt++;
        if (q_in !== 16'h0002) $display("FAIL stop_tick_q2: got %h want 0002", q_in);
        else pass_cnt++;
    endtask

`ifdef BCD_CHAIN_CTRL_LIMIT_EN
    task automatic test_limit();
        int hits;
        hits  = 0;
        limit = 16'h0007;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (hit === 1'b1) hits++;
            step();
        end
        check_cnt++;
        if (hits != 1) $display("FAIL limit_hits: got %0d want 1", hits);
        else pass_cnt++;
        check_cnt++;
        if ({state, q_in} !== {2'd3, 16'h0007})
            $display("FAIL limit_done: got %0d/%h want 3/0007", state, q_in);
        else pass_cnt++;
        start = 1'b1;
        step();
        start = 1'b0;
        check_cnt++;
        if (state !== 2'd3) $display("FAIL limit_start_ignored: got %0d want 3", state);
        else pass_cnt++;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        check_cnt++;
        if ({state, q_in} !== {2'd0, 16'h0000})
            $display("FAIL limit_clear: got %0d/%h want 0/0000", state, q_in);
        else pass_cnt++;
    endtask
`else
    task automatic test_limit();
        // Compare is not built: limit matching the count must do nothing.
        limit = 16'h0000;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_cnt++;
        if ({state, hit} !== {2'd1, 1'b0})
            $display("FAIL limit_off: got %0d/%b want 1/0", state, hit);
        else pass_cnt++;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask
`endif

    initial begin
        pass_cnt    = 0;
        check_cnt   = 0;
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        clear       = 1'b0;
        limit       = '1;
        preload_en  = 1'b0;
        preload_val = '0;
        test_reset();
        test_count();
        test_clear();
        test_wrap();
        test_pause_resume();
        test_clear();
        test_limit();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_chain_ctrl.md
# bcd_chain_ctrl

Sequencer for a chain of NDIG single-digit BCD counters; each digit has an `enable`, an active-low `reset_n`, a `Q[3:0]` output and a `done` flag (`done` = `Q`==9). The block turns start/stop/clear commands into a divided count tick and ripples per-digit enables through the `done` flags, so the digits form one multi-digit decimal counter. It owns the run state, the digit clear, wrap-around reporting and an optional terminal-count stop. It sits between the control logic (buttons or CPU strobes) and the digit counter instances.

## Interface
- NDIG, default 4, number of BCD digits in the chain (1..8)
- DIV, default 4, clock cycles per count tick (≥2)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe: begin or resume counting
- stop  in  1  command strobe: pause counting
- clear  in  1  command strobe: zero all digits, return to IDLE
- digit_done  in  NDIG  `done` of each digit; bit 0 = least significant digit
- q_in  in  4*NDIG  concatenated digit `Q`, digit 0 in [3:0]
- limit  in  4*NDIG  terminal count, BCD; used only with the limit feature
- digit_en  out  NDIG  per-digit `enable`, combinational
- digit_clr_n  out  1  active-low clear to all digit `reset_n`, registered
- running  out  1  state == RUN
- wrap  out  1  one-cycle pulse when the chain rolls from all-9s to all-0s
- hit  out  1  one-cycle pulse on reaching `limit`
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- FSM states: IDLE, RUN, PAUSE, DONE.
- Command priority in a cycle: `clear` > `stop` > `start`. Lower-priority commands in the same cycle are ignored.
- `clear` from any state:
  - next state IDLE; prescaler reset to 0
  - `digit_clr_n` low for exactly the next cycle
- IDLE or PAUSE + `start` → RUN. RUN + `stop` → PAUSE. DONE ignores `start` and `stop`; only `clear` or `reset` exits DONE.
- Prescaler `pre` counts 0..DIV-1 only in RUN and holds its value in PAUSE, so a resume continues the partial period.
- `tick` = (state==RUN) & (`pre`==DIV-1) & ~`stop` & ~`clear`.
- `digit_en[0]` = `tick`. `digit_en[i]` = `tick` & AND of `digit_done[i-1:0]`.
- `wrap` = `tick` & (&`digit_done`), registered, so it pulses the cycle after the roll edge. Counting continues after a wrap.
- `hit` is 0 unless the limit feature is compiled in.

## Timing
- Reset values:
  - state IDLE, `pre`=0
  - `digit_clr_n`=0 while reset is high; first cycle after reset it is 0, then 1
  - `digit_en`=0, `running`=0, `wrap`=0, `hit`=0
- `start` sampled at edge k → `running`=1 after edge k. The first `tick` occurs in cycle k+DIV, and the digits advance at edge k+DIV.
- `digit_en` is combinational, so the digits advance on the same edge as `tick`. Tick spacing is exactly DIV cycles of RUN time.
- `stop` in a tick cycle suppresses that tick.
- Reset mid-count overrides everything. The digits are cleared through `digit_clr_n`.

## Configuration
- `BCD_CHAIN_CTRL_LIMIT_EN` defined:
  - in RUN, when `q_in`==`limit`, the next state is DONE and `hit` pulses for one cycle
  - the compare is on current digit values, so the count stops showing `limit`
  - `limit` = 0 with counter at 0: DONE one cycle after entering RUN
  - `limit` never matched: normal wrap behaviour
- `BCD_CHAIN_CTRL_LIMIT_EN` undefined:
  - no compare logic; DONE is unreachable
  - `hit` tied 0; `limit` ignored

## Test plan
- Reset held 3 cycles, then released → state=0, `digit_en`=0, `digit_clr_n` 0 through the first post-reset cycle, then 1.
- NDIG=4, DIV=4, `start` pulse → `digit_en[0]` high one cycle every 4 cycles. After 10 ticks, `q_in`=0x0010, and `digit_en[1]` was high only on the tick where digit 0 = 9.
- Preload digits to 0x9999, run one tick → all of `digit_en` high in that cycle, `q_in`=0x0000, `wrap` pulses the next cycle.
- Pause/resume: `stop` with `pre`=2, hold 7 cycles, then `start` → next tick 2 cycles after resume. `stop` in a tick cycle → no increment.
- Same-cycle `start`+`stop`+`clear` in RUN → IDLE, `digit_clr_n` low 1 cycle, `q_in`=0.
- With `BCD_CHAIN_CTRL_LIMIT_EN`, `limit`=0x0007 → `hit` pulses once, state=3, `q_in` stays 0x0007, `start` ignored until `clear`.
